// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard sequencer driving per-stage stall/flush for the 5-stage pipeline.
// Optional perf counters (stall_cnt/flush_cnt) enabled by defining HAZ_PERF_CNT_EN.
module pipeline_stall_ctrl #(
    parameter int MDU_LAT = 32
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rdE,
    input  logic       MemReadE,
    input  logic       PCSrcE,
    input  logic       MduStartE,
    input  logic       MduDoneE,
    input  logic       MemReqM,
    input  logic       MemReadyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic       FlushW,
    output logic       mdu_timeout,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0] state_o
);
    localparam int CW = $clog2(MDU_LAT + 1);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, MDU_BUSY = 2'b10} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic timeout_set, memwait, lu, at_lat;
    logic mw_out, md_out, br_out, lu_out;
    assign memwait = MemReqM & ~MemReadyM;
    assign lu = MemReadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
    assign at_lat = cnt == CW'(MDU_LAT);
    assign state_o = state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt <= '0;
            mdu_timeout <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (timeout_set) mdu_timeout <= 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        timeout_set = 1'b0;
        case (state)
            RUN:
                if (memwait) state_n = MEM_WAIT;
                else if (MduStartE) begin
                    state_n = MDU_BUSY;
                    cnt_n = CW'(1);
                end
            MEM_WAIT: if (!memwait) state_n = RUN;
            MDU_BUSY:
                if (MduDoneE || at_lat) begin
                    state_n = RUN;
                    cnt_n = '0;
                    timeout_set = ~MduDoneE;
                end else cnt_n = cnt + CW'(1);
            default: state_n = RUN;
        endcase
    end
    // Outputs are forced low while reset is held, independent of the clock.
    always_comb begin
        mw_out = rst_n & (state != MDU_BUSY) & memwait;
        md_out = rst_n & ((state == RUN & ~memwait & MduStartE) | (state == MDU_BUSY & ~MduDoneE & ~at_lat));
        br_out = rst_n & (state == RUN) & ~memwait & ~MduStartE & PCSrcE;
        lu_out = rst_n & (state == RUN) & ~memwait & ~MduStartE & ~PCSrcE & lu;
        StallF = mw_out | md_out | lu_out;
        StallD = mw_out | md_out | lu_out;
        StallE = mw_out | md_out;
        StallM = mw_out;
        FlushD = br_out;
        FlushE = br_out | lu_out;
        FlushM = md_out;
        FlushW = mw_out;
    end
`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if ((FlushD | FlushE | FlushM | FlushW) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule
